// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the synchronous instruction BRAM and presents the
// returned word with its PC to decode, handling stall, redirect and warm-up after reset.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        inst_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] fetch_pc_r;
  logic        misaligned_r;
  logic [31:0] imem_addr_s;
  logic        inst_valid_s;
  logic [31:0] inst_out_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Next fetch address; before RUN the BRAM is re-read at fetch_pc so RUN starts on it.
  always_comb begin
    imem_addr_s = fetch_pc_r + 32'd4;
    if (Reset) begin
      imem_addr_s = RESET_PC;
    end else if (redirect) begin
      imem_addr_s = word_align(redirect_target);
    end else if (stall || (state_r != ST_RUN)) begin
      imem_addr_s = fetch_pc_r;
    end else begin
      imem_addr_s = fetch_pc_r + 32'd4;
    end
  end

  // Warm-up sequencing, fetch address register and sticky misalignment flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= ST_RST;
      fetch_pc_r   <= RESET_PC;
      misaligned_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RST:  state_r <= ST_WARM;
        ST_WARM: state_r <= ST_RUN;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_RST;
      endcase
      fetch_pc_r   <= imem_addr_s;
      misaligned_r <= misaligned_r | (redirect & (redirect_target[1:0] != 2'b00));
    end
  end

  // A redirect kills the instruction already returned for the wrong path.
  always_comb begin
    inst_valid_s = 1'b0;
    inst_out_s   = NOP_INST;
    if ((state_r == ST_RUN) && !redirect && !Reset) begin
      inst_valid_s = 1'b1;
      inst_out_s   = imem_dout;
    end else begin
      inst_valid_s = 1'b0;
      inst_out_s   = NOP_INST;
    end
  end

  assign imem_addr  = imem_addr_s;
  assign inst_valid = inst_valid_s;
  assign inst_out   = inst_out_s;
  assign pc_out     = fetch_pc_r;
  assign npc_out    = fetch_pc_r + 32'd4;
  assign misaligned = misaligned_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a BRAM model feeds the DUT, expectations are queued
// with each cycle's stimulus and compared mid-cycle.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0000_0000;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        inst_valid;
  logic        misaligned;

  typedef struct {
    int          idx;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;

  inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .Clock(Clock), .Reset(Reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .inst_out(inst_out), .pc_out(pc_out), .npc_out(npc_out),
    .inst_valid(inst_valid), .misaligned(misaligned)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
  endfunction

  // Synchronous-read instruction memory model.
  always @(posedge Clock) imem_dout <= mem_word(imem_addr);

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                       input logic emis);
    exp_t e;
    @(negedge Clock);
    Reset = r;
    stall = s;
    redirect = rd;
    redirect_target = tgt;
    step++;
    e.idx = step;
    e.valid = ev;
    e.pc = epc;
    e.addr = eaddr;
    e.mis = emis;
    exp_q.push_back(e);
  endtask

  // Mid-cycle monitor: pops the expectation queued for this cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32($sformatf("c%0d.valid", e.idx), {31'd0, inst_valid}, {31'd0, e.valid});
        check32($sformatf("c%0d.addr", e.idx), imem_addr, e.addr);
        check32($sformatf("c%0d.pc", e.idx), pc_out, e.pc);
        check32($sformatf("c%0d.npc", e.idx), npc_out, e.pc + 32'd4);
        check32($sformatf("c%0d.inst", e.idx), inst_out, e.valid ? mem_word(e.pc) : NOP_INST);
        check32($sformatf("c%0d.mis", e.idx), {31'd0, misaligned}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    //     rst   stl   rdr   target         valid pc             addr           mis
    drive(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         32'h8,         1'b0);
    // stall holding pc 8
    drive(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h8,         1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h8,         1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h8,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'hC,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         32'h10,        1'b0);
    // redirect to 0x100 while pc 0x10
    drive(1'b0, 1'b0, 1'b1, 32'h100,       1'b0, 32'h10,        32'h100,       1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       32'h104,       1'b0);
    // stall and redirect together, stall kept one more cycle
    drive(1'b0, 1'b1, 1'b1, 32'h40,        1'b0, 32'h104,       32'h40,        1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        32'h40,        1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h40,        32'h44,        1'b0);
    // misaligned target
    drive(1'b0, 1'b0, 1'b1, 32'h102,       1'b0, 32'h44,        32'h100,       1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       32'h104,       1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h1FC,       1'b0, 32'h104,       32'h1FC,       1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1FC,       32'h200,       1'b1);
    // reset pulse at pc 0x200, with stall and redirect asserted too
    drive(1'b1, 1'b1, 1'b1, 32'h500,       1'b0, 32'h200,       32'h0,         1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
    // redirect during warm-up retargets the first RUN fetch
    drive(1'b0, 1'b0, 1'b1, 32'h300,       1'b0, 32'h0,         32'h300,       1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h300,       32'h304,       1'b0);
    // wrap of npc and sequential address at the top of memory
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h304,       32'hFFFF_FFFC, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         32'h0,         1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0);
    @(negedge Clock);
    #3;
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
